// File: rtl/sdio_data_xfer_pkg.sv
// Shared types and constants for the SDIO block-transfer sequencer.
// Optional WAIT_PHY timeout build: define SDIO_DATA_XFER_TIMEOUT_EN.
package sdio_data_xfer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACTIVATE,
        ST_WAIT_PHY,
        ST_TOKEN,
        ST_BUSY,
        ST_GAP,
        ST_END
    } xfer_state_e;

    localparam logic [2:0]  TOK_GOOD        = 3'b010;
    localparam logic [2:0]  TOK_BAD         = 3'b101;
    localparam int unsigned MAX_BLOCK_BYTES = 512;
    localparam int unsigned COUNT_W         = 10;
    localparam int unsigned BLK_W           = 9;

    // A zero size field encodes the maximum block length.
    function automatic logic [COUNT_W-1:0] size_or_max(input logic [COUNT_W-1:0] v);
        return (v == '0) ? COUNT_W'(MAX_BLOCK_BYTES) : v;
    endfunction

endpackage

// File: rtl/sdio_xfer_timer.sv
// Loadable down-counter shared by the busy, gap and timeout intervals.
module sdio_xfer_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk_x2,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero_c
);

    logic [W-1:0] count;

    always_ff @(posedge clk_x2) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/sdio_data_xfer_ctrl.sv
// CMD53 block-transfer sequencer driving sdio_data_phy one block at a time.
// Define SDIO_DATA_XFER_TIMEOUT_EN to bound the wait for phy completion.
module sdio_data_xfer_ctrl #(
    parameter int unsigned BUSY_CYCLES = 8,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned TIMEOUT     = 4096
) (
    input  logic       clk_x2,
    input  logic       rst,
    input  logic       i_xfer_start,
    input  logic       i_xfer_write,
    input  logic       i_block_mode,
    input  logic [9:0] i_block_size,
    input  logic [8:0] i_block_count,
    input  logic [9:0] i_byte_count,
    input  logic       i_abort,
    output logic       o_busy,
    output logic       o_xfer_done,
    output logic       o_xfer_err,
    output logic       o_xfer_aborted,
    output logic [8:0] o_blocks_done,
    output logic       o_phy_activate,
    output logic       o_phy_write,
    output logic [9:0] o_phy_count,
    input  logic       i_phy_finished,
    input  logic       i_phy_crc_good,
    output logic       o_tok_stb,
    output logic [2:0] o_tok,
    output logic       o_dat0_busy
);

    import sdio_data_xfer_pkg::*;

    localparam int unsigned MAX_BG   = (BUSY_CYCLES > GAP_CYCLES) ? BUSY_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_LOAD = (TIMEOUT > MAX_BG) ? TIMEOUT : MAX_BG;
    localparam int unsigned TIMER_W  = $clog2(MAX_LOAD + 1);

    xfer_state_e        state;
    logic [BLK_W-1:0]   remaining;
    logic               infinite;
    logic               last_blk;
    logic               crc_bad;
    logic               fin_seen;
    logic               abort_c;
    logic               blk_done_c;
    logic               tmr_load_c;
    logic [TIMER_W-1:0] tmr_val_c;
    logic               tmr_zero_c;

    // Interval loads: busy after a token, gap after a good read block, optional phy timeout.
    always_comb begin
        abort_c    = i_abort && (state != ST_IDLE) && (state != ST_END);
        blk_done_c = (state == ST_WAIT_PHY) && i_phy_finished && fin_seen;
        tmr_load_c = 1'b0;
        tmr_val_c  = '0;
        case (state)
`ifdef SDIO_DATA_XFER_TIMEOUT_EN
            ST_ACTIVATE: begin
                tmr_load_c = 1'b1;
                tmr_val_c  = TIMER_W'(TIMEOUT - 1);
            end
`endif
            ST_TOKEN: begin
                tmr_load_c = 1'b1;
                tmr_val_c  = TIMER_W'(BUSY_CYCLES - 1);
            end
            ST_WAIT_PHY: begin
                if (blk_done_c && !o_phy_write && i_phy_crc_good) begin
                    tmr_load_c = 1'b1;
                    tmr_val_c  = TIMER_W'(GAP_CYCLES - 1);
                end
            end
            default: ;
        endcase
    end

    sdio_xfer_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk_x2   (clk_x2),
        .rst      (rst),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .zero_c   (tmr_zero_c)
    );

    // Outputs are updated on entry to each state so they line up with it.
    always_ff @(posedge clk_x2) begin
        if (rst) begin
            state          <= ST_IDLE;
            remaining      <= '0;
            infinite       <= 1'b0;
            last_blk       <= 1'b0;
            crc_bad        <= 1'b0;
            fin_seen       <= 1'b0;
            o_busy         <= 1'b0;
            o_xfer_done    <= 1'b0;
            o_xfer_err     <= 1'b0;
            o_xfer_aborted <= 1'b0;
            o_blocks_done  <= '0;
            o_phy_activate <= 1'b0;
            o_phy_write    <= 1'b0;
            o_phy_count    <= '0;
            o_tok_stb      <= 1'b0;
            o_tok          <= '0;
            o_dat0_busy    <= 1'b0;
        end else if (abort_c) begin
            state          <= ST_END;
            o_xfer_done    <= 1'b1;
            o_xfer_err     <= 1'b0;
            o_xfer_aborted <= 1'b1;
            o_phy_activate <= 1'b0;
            o_tok_stb      <= 1'b0;
            o_tok          <= '0;
            o_dat0_busy    <= 1'b0;
            fin_seen       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_xfer_start) begin
                        state          <= ST_ACTIVATE;
                        o_busy         <= 1'b1;
                        o_phy_activate <= 1'b1;
                        o_phy_write    <= i_xfer_write;
                        o_phy_count    <= i_block_mode ? size_or_max(i_block_size)
                                                       : size_or_max(i_byte_count);
                        remaining      <= i_block_mode ? i_block_count : BLK_W'(1);
                        infinite       <= i_block_mode && (i_block_count == '0);
                        o_blocks_done  <= '0;
                        crc_bad        <= 1'b0;
                        last_blk       <= 1'b0;
                        fin_seen       <= 1'b0;
                    end
                end
                ST_ACTIVATE: begin
                    state <= ST_WAIT_PHY;
                end
                ST_WAIT_PHY: begin
                    if (blk_done_c) begin
                        // crc_good is only valid from the second FINISHED cycle.
                        fin_seen       <= 1'b0;
                        o_phy_activate <= 1'b0;
                        o_blocks_done  <= o_blocks_done + BLK_W'(1);
                        remaining      <= remaining - BLK_W'(1);
                        last_blk       <= !infinite && (remaining == BLK_W'(1));
                        crc_bad        <= !i_phy_crc_good;
                        if (o_phy_write) begin
                            state     <= ST_TOKEN;
                            o_tok_stb <= 1'b1;
                            o_tok     <= i_phy_crc_good ? TOK_GOOD : TOK_BAD;
                        end else if (i_phy_crc_good) begin
                            state <= ST_GAP;
                        end else begin
                            state       <= ST_END;
                            o_xfer_done <= 1'b1;
                            o_xfer_err  <= 1'b1;
                        end
                    end else if (i_phy_finished) begin
                        fin_seen <= 1'b1;
                    end else begin
                        fin_seen <= 1'b0;
`ifdef SDIO_DATA_XFER_TIMEOUT_EN
                        if (tmr_zero_c) begin
                            state          <= ST_END;
                            o_xfer_done    <= 1'b1;
                            o_xfer_err     <= 1'b1;
                            o_phy_activate <= 1'b0;
                        end
`endif
                    end
                end
                ST_TOKEN: begin
                    state       <= ST_BUSY;
                    o_tok_stb   <= 1'b0;
                    o_tok       <= '0;
                    o_dat0_busy <= 1'b1;
                end
                ST_BUSY: begin
                    if (tmr_zero_c) begin
                        o_dat0_busy <= 1'b0;
                        if (crc_bad || last_blk) begin
                            state       <= ST_END;
                            o_xfer_done <= 1'b1;
                            o_xfer_err  <= crc_bad;
                        end else begin
                            state          <= ST_ACTIVATE;
                            o_phy_activate <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (tmr_zero_c) begin
                        if (last_blk) begin
                            state       <= ST_END;
                            o_xfer_done <= 1'b1;
                            o_xfer_err  <= 1'b0;
                        end else begin
                            state          <= ST_ACTIVATE;
                            o_phy_activate <= 1'b1;
                        end
                    end
                end
                ST_END: begin
                    state          <= ST_IDLE;
                    o_busy         <= 1'b0;
                    o_xfer_done    <= 1'b0;
                    o_xfer_err     <= 1'b0;
                    o_xfer_aborted <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
